// File: rtl/mult_shift_add_32.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier.
// A single 32-bit adder is reused for all 32 iterations, one per clock.

module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] full_sum;

  // Plain ripple/carry add; the carry-out is kept as the 33rd bit.
  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b} + {32'b0, cin};
  end

  assign sum  = full_sum[31:0];
  assign cout = full_sum[32];

endmodule

// state | meaning
// IDLE  | waiting for start, product holds last result
// RUN   | one add/shift iteration per cycle, 32 in total
// DONE  | one-cycle result-valid pulse, start may be accepted here

module mult_shift_add_32 #(
  parameter int WIDTH = 32  // the shared adder is fixed at 32 bits
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [5:0]  count_q, count_d;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cout;

  // The multiplier bit currently at lo[0] selects whether mcand is added.
  always_comb begin
    add_a = hi_q;
    add_b = lo_q[0] ? mcand_q : 32'h0;
  end

  adder_32 u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State and datapath registers; rst clears everything, aborting any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= 32'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      count_q <= 6'd0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          mcand_d = a;
          hi_d    = 32'h0;
          lo_d    = b;
          count_d = 6'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Shift the 65-bit {cout,sum,lo} right by one; cout lands in hi[31].
        {hi_d, lo_d} = {add_cout, add_sum, lo_q[31:1]};
        if (count_q == 6'd31) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status and result outputs come straight from registers.
  always_comb begin
    busy    = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    product = {hi_q, lo_q};
  end

endmodule
